// File: rtl/maze_mem_ctrl.sv
// Maze cell memory controller: one 256x2 single-port store shared between the
// VGA pixel reader (priority) and a buffered cell-update writer, plus a clear sweep.
module maze_mem_ctrl #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [1:0] CLEAR_VALUE = 2'b00
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [9:0] PIX_X,
  input  logic [9:0] PIX_Y,
  output logic [1:0] CELL_VALUE,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [3:0] WR_ROW,
  input  logic [3:0] WR_COL,
  input  logic [1:0] WR_VALUE,
  input  logic       CLEAR_REQ,
  output logic       BUSY,
  output logic       DROP,
  output logic       dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    mem [256];
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          drop_q;

  logic       in_display;
  logic [7:0] disp_addr;
  logic       full, empty;
  logic       ready, busy, pop, push, accept, flush, drop_set;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [1:0] mem_wdata;
  logic [9:0] head;
  logic       unused_bits;

  assign in_display  = (PIX_X < 10'd512) && (PIX_Y < 10'd480);
  assign disp_addr   = {PIX_Y[8:5], PIX_X[8:5]};
  assign unused_bits = ^{PIX_X[4:0], PIX_Y[4:0]};

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = fifo_mem[rd_ptr_q];

  // Update handshake: an update transfers on a rising edge where WR_VALID and
  // WR_READY are both high; WR_READY never depends on WR_VALID.
  assign accept   = WR_VALID && ready;
  assign flush    = CLEAR_REQ && (state_q == ST_RUN);
  assign push     = accept && (WR_ROW != 4'd15) && !flush;
  assign drop_set = (accept && ((WR_ROW == 4'd15) || flush)) || (flush && !empty);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Port arbitration: clear sweep owns the port; in RUN the display wins and
  // buffered updates only commit on non-display cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    ready     = 1'b0;
    pop       = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = CLEAR_VALUE;
    case (state_q)
      ST_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) state_d = ST_RUN;
      end
      ST_RUN: begin
        ready = !full;
        if (flush) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (!in_display && !empty) begin
          pop       = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = head[9:2];
          mem_wdata = head[1:0];
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      CELL_VALUE <= 2'b00;
    end else if (state_q == ST_CLEAR) begin
      CELL_VALUE <= CLEAR_VALUE;
    end else if (in_display) begin
      CELL_VALUE <= mem[disp_addr];
    end else begin
      CELL_VALUE <= 2'b00;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) fifo_mem[wr_ptr_q] <= {WR_ROW, WR_COL, WR_VALUE};
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (drop_set) drop_q <= 1'b1;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign WR_READY  = ready;
  assign BUSY      = busy;
  assign DROP      = drop_q;
  assign dbg_state = state_q;

endmodule
